// File: rtl/fm_mpx_modulator.sv
// Stereo MPX builder (L+R, DSB-SC L-R, pilot) feeding a dithered FM phase accumulator
// that drives an offset-binary DAC code. Single clock domain, synchronous reset.
module fm_mpx_modulator #(
  parameter int A = 8,
  parameter int L = 12,
  parameter int N = 18,
  parameter int M = 5,
  parameter int D = 4,
  parameter int P = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [A-1:0] audio_l,
  input  logic [A-1:0] audio_r,
  input  logic         audio_valid,
  input  logic         stereo_en,
  input  logic [3:0]   pilot_lvl,
  input  logic [P-1:0] pilot_inc,
  input  logic [N-1:0] acc_inc,
  input  logic [L-1:0] df_inc,
  input  logic         dith_en,
  output logic [A-1:0] mpx,
  output logic         pilot_sync,
  output logic [D-1:0] rf
);

  localparam int W    = 2*A + 3;
  localparam int MAXI = 2**(A-1) - 1;
  localparam int MINI = -(2**(A-1));

  // Quarter-wave table holds round(127*sin(2*pi*k/32)); folded to a full period.
  function automatic logic signed [A-1:0] sine_lut(input logic [M-1:0] k);
    int ki;
    int q;
    int v;
    ki = int'(k) % (2**(M-1));
    q  = (ki > 2**(M-2)) ? (2**(M-1) - ki) : ki;
    case (q)
      0: v = 0;
      1: v = 25;
      2: v = 49;
      3: v = 71;
      4: v = 90;
      5: v = 106;
      6: v = 117;
      7: v = 125;
      8: v = 127;
      default: v = 0;
    endcase
    if (int'(k) >= 2**(M-1)) v = -v;
    return A'(v);
  endfunction

  logic signed [A-1:0]   smp_l, smp_r;
  logic [P-1:0]          pacc;
  logic [N-1:0]          fw, phase;
  logic [15:0]           lfsr;

  logic [P:0]            pacc_sum;
  logic signed [A-1:0]   psin, sub;
  logic signed [A:0]     sum, diff;
  logic signed [2*A:0]   dsb_prod, dsb;
  logic signed [A+4:0]   pt_prod, pterm;
  logic signed [W-1:0]   st_sum;
  logic signed [A-1:0]   mpx_st, mpx_mono;
  logic signed [A+L:0]   dev_prod, dev;
  logic [N-1:0]          fw_next, ph_d;
  logic [15:0]           lfsr_next;
  logic signed [A-1:0]   car;
  logic [A-1:0]          car_ob;
  logic [D-1:0]          rf_next;

  assign pacc_sum = {1'b0, pacc} + {1'b0, pilot_inc};
  // Subcarrier index taken one bit lower than the pilot: twice the rate, phase-locked.
  assign psin     = sine_lut(M'(pacc >> (P-M)));
  assign sub      = sine_lut(M'(pacc >> (P-M-1)));

  assign sum      = (A+1)'(smp_l) + (A+1)'(smp_r);
  assign diff     = (A+1)'(smp_l) - (A+1)'(smp_r);
  assign dsb_prod = (2*A+1)'(diff) * (2*A+1)'(sub);
  assign dsb      = dsb_prod >>> (A-1);
  assign pt_prod  = (A+5)'(psin) * (A+5)'($signed({1'b0, pilot_lvl}));
  assign pterm    = pt_prod >>> 6;
  assign st_sum   = W'(sum >>> 1) + W'(dsb >>> 1) + W'(pterm);
  assign mpx_mono = A'(sum >>> 1);

  always_comb begin
    mpx_st = A'(st_sum);
    if (st_sum > W'(MAXI))      mpx_st = A'(MAXI);
    else if (st_sum < W'(MINI)) mpx_st = A'(MINI);
  end

  assign dev_prod  = (A+L+1)'($signed(mpx)) * (A+L+1)'($signed({1'b0, df_inc}));
  assign dev       = dev_prod >>> (A-1);
  assign fw_next   = acc_inc + N'(dev);

  assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

  // Dither only perturbs the LUT address; the accumulator itself stays clean.
  assign ph_d    = phase + (dith_en ? N'(lfsr[N-M-1:0]) : '0);
  assign car     = sine_lut(M'(ph_d >> (N-M)));
  assign car_ob  = {~car[A-1], car[A-2:0]};
  assign rf_next = D'(car_ob >> (A-D));

  always_ff @(posedge clk) begin
    if (rst) begin
      smp_l      <= '0;
      smp_r      <= '0;
      pacc       <= '0;
      pilot_sync <= 1'b0;
      mpx        <= '0;
      fw         <= '0;
      phase      <= '0;
      lfsr       <= 16'hACE1;
      rf         <= '0;
    end else begin
      if (audio_valid) begin
        smp_l <= audio_l;
        smp_r <= audio_r;
      end
      pacc       <= pacc_sum[P-1:0];
      pilot_sync <= pacc_sum[P];
      mpx        <= stereo_en ? mpx_st : mpx_mono;
      fw         <= fw_next;
      phase      <= phase + fw;
      lfsr       <= lfsr_next;
      rf         <= rf_next;
    end
  end

endmodule

// File: tb/tb_fm_mpx_modulator.sv
// Directed self-checking bench for fm_mpx_modulator: reset, carrier, pilot,
// stereo saturation, deviation, dither, back-to-back samples, mid-stream reset.
module tb_fm_mpx_modulator;

  logic        clk;
  logic        rst;
  logic [7:0]  audio_l, audio_r;
  logic        audio_valid;
  logic        stereo_en;
  logic [3:0]  pilot_lvl;
  logic [15:0] pilot_inc;
  logic [17:0] acc_inc;
  logic [11:0] df_inc;
  logic        dith_en;
  logic [7:0]  mpx;
  logic        pilot_sync;
  logic [3:0]  rf;

  int checks;
  int failures;

  fm_mpx_modulator dut (
    .clk(clk), .rst(rst), .audio_l(audio_l), .audio_r(audio_r),
    .audio_valid(audio_valid), .stereo_en(stereo_en), .pilot_lvl(pilot_lvl),
    .pilot_inc(pilot_inc), .acc_inc(acc_inc), .df_inc(df_inc), .dith_en(dith_en),
    .mpx(mpx), .pilot_sync(pilot_sync), .rf(rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_lut(input int k);
    real pi;
    pi = 3.14159265358979;
    return int'(127.0 * $sin(2.0 * pi * real'(k) / 32.0));
  endfunction

  function automatic logic [3:0] ref_rf(input int k);
    logic [7:0] b;
    b = 8'(ref_lut(k));
    return {~b[7], b[6:4]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    audio_l = '0; audio_r = '0; audio_valid = 1'b0;
    stereo_en = 1'b0; pilot_lvl = '0; pilot_inc = '0;
    acc_inc = '0; df_inc = '0; dith_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    audio_l = 8'd55; audio_r = 8'd3; audio_valid = 1'b1;
    stereo_en = 1'b1; pilot_lvl = 4'd15; pilot_inc = 16'd4000;
    acc_inc = 18'd70000; df_inc = 12'd100; dith_en = 1'b1;
    tick();
    tick();
    checks++;
    if (mpx !== 8'd0) begin failures++; $display("FAIL reset_mpx got=%0d want=0", mpx); end
    checks++;
    if (pilot_sync !== 1'b0) begin failures++; $display("FAIL reset_pilot_sync got=%0b want=0", pilot_sync); end
    checks++;
    if (rf !== 4'd0) begin failures++; $display("FAIL reset_rf got=%0d want=0", rf); end
  endtask

  task automatic test_mono_carrier();
    logic [3:0] seq [4];
    seq = '{4'd8, 4'd15, 4'd8, 4'd0};
    do_reset();
    acc_inc = 18'h10000;
    rst = 1'b0;
    tick();
    checks++;
    if (rf !== 4'd8) begin failures++; $display("FAIL first_rf got=%0d want=8", rf); end
    for (int j = 2; j <= 13; j++) begin
      tick();
      checks++;
      if (rf !== seq[(j-2)%4]) begin
        failures++; $display("FAIL mono_carrier edge=%0d got=%0d want=%0d", j, rf, seq[(j-2)%4]);
      end
    end
  endtask

  task automatic test_pilot();
    logic want;
    do_reset();
    pilot_inc = 16'd2048;
    rst = 1'b0;
    for (int k = 1; k <= 96; k++) begin
      tick();
      want = (k % 32 == 0);
      checks++;
      if (pilot_sync !== want) begin
        failures++; $display("FAIL pilot_sync cycle=%0d got=%0b want=%0b", k, pilot_sync, want);
      end
    end
  endtask

  task automatic test_stereo_sat();
    logic signed [7:0] exp8 [8];
    // pacc steps 8192/cycle: subcarrier index 8k, pilot index 4k
    exp8 = '{8'sd127, 8'sd28, -8'sd107, -8'sd1, 8'sd103, -8'sd31, -8'sd128, -8'sd1};
    do_reset();
    stereo_en = 1'b1; pilot_lvl = 4'd15; pilot_inc = 16'd8192;
    audio_l = 8'd127; audio_r = 8'h80; audio_valid = 1'b1;
    rst = 1'b0;
    tick();
    audio_valid = 1'b0;
    for (int j = 2; j <= 17; j++) begin
      tick();
      checks++;
      if (mpx !== exp8[(j-2)%8]) begin
        failures++;
        $display("FAIL stereo_mpx edge=%0d got=%0d want=%0d", j, $signed(mpx), exp8[(j-2)%8]);
      end
    end
    stereo_en = 1'b0;
    tick();
    checks++;
    if (mpx !== 8'hFF) begin failures++; $display("FAIL mono_same_input got=%0d want=-1", $signed(mpx)); end
  endtask

  task automatic test_deviation();
    do_reset();
    audio_l = 8'd64; audio_r = 8'd64; audio_valid = 1'b1;
    df_inc = 12'd128; acc_inc = '0;
    rst = 1'b0;
    tick();
    audio_valid = 1'b0;
    tick();
    checks++;
    if (mpx !== 8'd64) begin failures++; $display("FAIL dev_mpx got=%0d want=64", $signed(mpx)); end
    // phase = 64*(j-3); LUT index steps to 1 when phase reaches 8192
    for (int j = 3; j <= 132; j++) begin
      tick();
      if (j == 131) begin
        checks++;
        if (rf !== 4'd8) begin failures++; $display("FAIL dev_rf_before edge=%0d got=%0d want=8", j, rf); end
      end else if (j == 132) begin
        checks++;
        if (rf !== 4'd9) begin failures++; $display("FAIL dev_rf_step edge=%0d got=%0d want=9", j, rf); end
      end
    end
    checks++;
    if (mpx !== 8'd64) begin failures++; $display("FAIL dev_mpx_hold got=%0d want=64", $signed(mpx)); end
  endtask

  task automatic run_dither(input logic [17:0] inc, input int ncyc);
    logic [15:0] m_lfsr;
    logic [17:0] m_phase, m_fw, t;
    logic [3:0]  want;
    do_reset();
    acc_inc = inc; dith_en = 1'b1;
    rst = 1'b0;
    m_lfsr = 16'hACE1; m_phase = '0; m_fw = '0;
    for (int j = 1; j <= ncyc; j++) begin
      t = m_phase + {5'b0, m_lfsr[12:0]};
      want = ref_rf(int'(t[17:13]));
      tick();
      checks++;
      if (rf !== want) begin
        failures++; $display("FAIL dither_rf inc=%0d edge=%0d got=%0d want=%0d", inc, j, rf, want);
      end
      m_phase = m_phase + m_fw;
      m_fw    = inc;
      m_lfsr  = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end
  endtask

  task automatic test_dither();
    run_dither(18'h10000, 16);
    run_dither(18'd5000, 60);
  endtask

  task automatic test_back_to_back();
    logic signed [7:0] ls [4];
    logic signed [7:0] rs [4];
    logic signed [7:0] ex [4];
    ls = '{8'sd10, -8'sd10, 8'sd127, -8'sd128};
    rs = '{8'sd20, -8'sd21, 8'sd127, -8'sd128};
    ex = '{8'sd15, -8'sd16, 8'sd127, -8'sd128};
    do_reset();
    rst = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      if (j <= 4) begin
        audio_l = ls[j-1]; audio_r = rs[j-1]; audio_valid = 1'b1;
      end else begin
        audio_valid = 1'b0;
      end
      tick();
      if (j >= 2) begin
        checks++;
        if (mpx !== ex[j-2]) begin
          failures++; $display("FAIL back_to_back idx=%0d got=%0d want=%0d", j-2, $signed(mpx), ex[j-2]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] seq [6];
    seq = '{4'd8, 4'd8, 4'd15, 4'd8, 4'd0, 4'd8};
    do_reset();
    stereo_en = 1'b1; pilot_lvl = 4'd15; pilot_inc = 16'd8192; acc_inc = 18'h10000;
    audio_l = 8'd127; audio_r = 8'h80; audio_valid = 1'b1; df_inc = 12'd50;
    rst = 1'b0;
    for (int j = 0; j < 10; j++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (mpx !== 8'd0) begin failures++; $display("FAIL midrst_mpx got=%0d want=0", $signed(mpx)); end
    checks++;
    if (rf !== 4'd0) begin failures++; $display("FAIL midrst_rf got=%0d want=0", rf); end
    checks++;
    if (pilot_sync !== 1'b0) begin failures++; $display("FAIL midrst_pilot_sync got=%0b want=0", pilot_sync); end
    audio_valid = 1'b0; df_inc = '0;
    rst = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      tick();
      checks++;
      if (rf !== seq[j-1]) begin
        failures++; $display("FAIL midrst_restart edge=%0d got=%0d want=%0d", j, rf, seq[j-1]);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_mono_carrier();
    test_pilot();
    test_stereo_sat();
    test_deviation();
    test_dither();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
